// File: rtl/video_timing_pkg.sv
// 720p raster constants and coordinate widths, shared by the timing generator,
// video_renderer and the frame-buffer writer.
package video_timing_pkg;

    localparam int ACTIVE_H = 1280;
    localparam int H_FP     = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int ACTIVE_V = 720;
    localparam int V_FP     = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 20;

    localparam int TOTAL_H  = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V  = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

endpackage

// File: rtl/video_sig_gen_sig_pipe.sv
// Fixed-latency shift register with async active-low reset to 0; DEPTH 0 is a wire.
module sig_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    if (DEPTH == 0) begin : g_wire
        assign q_out = d_in;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        logic [DEPTH-1:0][WIDTH-1:0] stage_d;

        always_comb begin
            stage_d    = stage_q;
            stage_d[0] = d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator: coordinates, sync/active/new-frame
// strobes, frame counter, and pipeline-aligned delayed sync/active copies.
module video_sig_gen #(
    parameter int ACTIVE_H   = video_timing_pkg::ACTIVE_H,
    parameter int H_FP       = video_timing_pkg::H_FP,
    parameter int H_SYNC     = video_timing_pkg::H_SYNC,
    parameter int H_BP       = video_timing_pkg::H_BP,
    parameter int ACTIVE_V   = video_timing_pkg::ACTIVE_V,
    parameter int V_FP       = video_timing_pkg::V_FP,
    parameter int V_SYNC     = video_timing_pkg::V_SYNC,
    parameter int V_BP       = video_timing_pkg::V_BP,
    parameter int FC_W       = 6,
    parameter int PIPE_DELAY = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    output logic [video_timing_pkg::HCOUNT_W-1:0] hcount_out,
    output logic [video_timing_pkg::VCOUNT_W-1:0] vcount_out,
    output logic                                hs_out,
    output logic                                vs_out,
    output logic                                ad_out,
    output logic                                nf_out,
    output logic [FC_W-1:0]                     fc_out,
    output logic                                hs_dly_out,
    output logic                                vs_dly_out,
    output logic                                ad_dly_out
);

    localparam int HW      = video_timing_pkg::HCOUNT_W;
    localparam int VW      = video_timing_pkg::VCOUNT_W;
    localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(TOTAL_H - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(TOTAL_V - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(ACTIVE_H);
    localparam logic [VW-1:0] V_ACT    = VW'(ACTIVE_V);
    localparam logic [HW-1:0] HS_START = HW'(ACTIVE_H + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(ACTIVE_V + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(ACTIVE_V + V_FP + V_SYNC);

    logic [HW-1:0]   hcount_q, hcount_d;
    logic [VW-1:0]   vcount_q, vcount_d;
    logic            hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
    logic [FC_W-1:0] fc_q, fc_d;

    // Flags are decoded from the next coordinates so they register alongside them.
    always_comb begin
        hcount_d = hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
        end
        ad_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hs_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
        vs_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
        nf_d = (hcount_d == H_ACT) && (vcount_d == V_ACT);
        fc_d = nf_d ? fc_q + FC_W'(1) : fc_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;
    assign ad_out     = ad_q;
    assign nf_out     = nf_q;
    assign fc_out     = fc_q;

    sig_pipe #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_sig_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({hs_q, vs_q, ad_q}),
        .q_out  ({hs_dly_out, vs_dly_out, ad_dly_out})
    );

endmodule
